wb_select_stage: RTL and testbench

//  Registered, parametrised writeback-source selector closing the MEM/WB boundary.

---
 rtl/wb_select_stage.sv | 138 +++++++++++++
 tb/tb_wb_select_stage.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_stage.sv
// MEM/WB writeback-source select stage with valid/ready, stall, flush.
// Optional committed-write counter when WB_PERF_CNT_EN is defined.
module wb_select_stage #(
  parameter int WIDTH  = 32,
  parameter int NSRC   = 3,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic                  reg_write,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  err_clr,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  sel_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_wr_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                err_q, err_d;

  logic [31:0]         sel_ext;
  logic                sel_legal;
  logic                capture;
  logic [WIDTH-1:0]    sel_data;

  assign in_ready  = ~stall;
  assign capture   = in_valid & in_ready & ~flush;
  assign sel_ext   = 32'(src_sel);
  assign sel_legal = sel_ext < 32'(NSRC);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_ext == 32'(i)) begin
        sel_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush) begin
      state_d = EMPTY;
      we_d    = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (capture) begin
      state_d = FULL;
      addr_d  = rd_addr;
      if (sel_legal) begin
        data_d = sel_data;
        we_d   = reg_write & (rd_addr != '0);
      end else begin
        data_d = '0;
        we_d   = 1'b0;
      end
    end else begin
      state_d = EMPTY;
      we_d    = 1'b0;
    end
    // A stall freezes sel_err too; set beats clear.
    if (err_clr & (flush | ~stall)) begin
      err_d = 1'b0;
    end
    if (capture & ~sel_legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign wb_valid = (state_q == FULL);
  assign wb_we    = we_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign sel_err  = err_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (we_q & ~stall) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_wr_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios plus random run
// against a rule-level model; counter checks need WB_PERF_CNT_EN.
module tb_wb_select_stage;
  localparam int WIDTH  = 32;
  localparam int NSRC   = 3;
  localparam int SEL_W  = 2;
  localparam int ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]      src_sel;
  logic                  reg_write;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  err_clr;
  logic                  wb_valid;
  logic                  wb_we;
  logic [ADDR_W-1:0]     wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic                  sel_err;
`ifdef WB_PERF_CNT_EN
  logic [31:0]           perf_wr_cnt;
`endif

  logic [WIDTH-1:0]  src [NSRC];

  logic              exp_v;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [WIDTH-1:0]  exp_data;
  logic              exp_err;
  logic [31:0]       exp_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_select_stage #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .reg_write  (reg_write),
    .rd_addr    (rd_addr),
    .err_clr    (err_clr),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .sel_err    (sel_err)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  task automatic set_src(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] c);
    src[0] = a;
    src[1] = b;
    src[2] = c;
    src_data = {src[2], src[1], src[0]};
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
    reg_write = 1'b0;
    src_sel   = '0;
    rd_addr   = '0;
  endtask

  // Advance one clock, evolving the expected state from the rules.
  task automatic tick();
    if (!rst_n) begin
      exp_v    = 1'b0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_err  = 1'b0;
      exp_cnt  = '0;
    end else begin
      if (exp_we && !stall) exp_cnt = exp_cnt + 1;
      if (flush) begin
        exp_v  = 1'b0;
        exp_we = 1'b0;
        if (err_clr) exp_err = 1'b0;
      end else if (stall) begin
        exp_v = exp_v;
      end else if (in_valid) begin
        exp_v    = 1'b1;
        exp_addr = rd_addr;
        if (int'(src_sel) < NSRC) begin
          exp_data = src[src_sel];
          exp_we   = reg_write && (rd_addr != 0);
          if (err_clr) exp_err = 1'b0;
        end else begin
          exp_data = '0;
          exp_we   = 1'b0;
          exp_err  = 1'b1;
        end
      end else begin
        exp_v  = 1'b0;
        exp_we = 1'b0;
        if (err_clr) exp_err = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'($urandom);
      stall     = 1'($urandom);
      flush     = 1'($urandom);
      err_clr   = 1'($urandom);
      reg_write = 1'($urandom);
      src_sel   = SEL_W'($urandom);
      rd_addr   = ADDR_W'($urandom);
      set_src($urandom, $urandom, $urandom);
      tick();
      n_cmp++;
      if ({wb_valid, wb_we, wb_addr, wb_data, sel_err} !== '0) begin
        n_bad++;
        $display("FAIL reset%0d: got v=%b we=%b a=%0d d=%h e=%b want 0",
                 i, wb_valid, wb_we, wb_addr, wb_data, sel_err);
      end
`ifdef WB_PERF_CNT_EN
      n_cmp++;
      if (perf_wr_cnt !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_cnt: got %0d want 0", perf_wr_cnt);
      end
`endif
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset: got v=%b we=%b want 0 0",
                 wb_valid, wb_we);
      end
    end
  endtask

  task automatic test_mux();
    logic [31:0] want;
    set_src(32'h11111111, 32'h22222222, 32'h33333333);
    for (int s = 0; s < NSRC; s++) begin
      in_valid  = 1'b1;
      reg_write = 1'b1;
      rd_addr   = 5'd7;
      src_sel   = SEL_W'(s);
      want      = 32'h11111111 * (s + 1);
      tick();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_we !== 1'b1 ||
          wb_addr !== 5'd7 || wb_data !== want) begin
        n_bad++;
        $display("FAIL mux sel%0d: got v=%b we=%b a=%0d d=%h want 1 1 7 %h",
                 s, wb_valid, wb_we, wb_addr, wb_data, want);
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'h33333333) begin
      n_bad++;
      $display("FAIL bubble: got v=%b we=%b d=%h want 0 0 33333333",
               wb_valid, wb_we, wb_data);
    end
  endtask

  task automatic test_zero_illegal();
    set_src(32'h11111111, 32'h22222222, 32'h33333333);
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd0;
    src_sel   = 2'd1;
    tick();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'h22222222) begin
      n_bad++;
      $display("FAIL zero_rd: got v=%b we=%b d=%h want 1 0 22222222",
               wb_valid, wb_we, wb_data);
    end
    rd_addr = 5'd9;
    src_sel = 2'd3;
    tick();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'd0 ||
        wb_addr !== 5'd9 || sel_err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal: got v=%b we=%b a=%0d d=%h e=%b want 1 0 9 0 1",
               wb_valid, wb_we, wb_addr, wb_data, sel_err);
    end
    idle_inputs();
    tick();
    tick();
    n_cmp++;
    if (sel_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", sel_err);
    end
    err_clr = 1'b1;
    tick();
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr: got %b want 0", sel_err);
    end
    in_valid = 1'b1;
    src_sel  = 2'd3;
    tick();
    n_cmp++;
    if (sel_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set_wins: got %b want 1", sel_err);
    end
    idle_inputs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_stall_flush();
    set_src(32'hAAAA5555, 32'h0BADF00D, 32'h12345678);
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd12;
    src_sel   = 2'd0;
    tick();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'hAAAA5555) begin
      n_bad++;
      $display("FAIL capture_a: got v=%b we=%b d=%h want 1 1 aaaa5555",
               wb_valid, wb_we, wb_data);
    end
    stall   = 1'b1;
    rd_addr = 5'd3;
    src_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_ready: got %b want 0", in_ready);
      end
      tick();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_we !== 1'b1 ||
          wb_addr !== 5'd12 || wb_data !== 32'hAAAA5555) begin
        n_bad++;
        $display("FAIL stall%0d: got v=%b we=%b a=%0d d=%h want 1 1 12 aaaa5555",
                 i, wb_valid, wb_we, wb_addr, wb_data);
      end
    end
    flush = 1'b1;
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall: got v=%b we=%b want 0 0", wb_valid, wb_we);
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'hAAAA5555) begin
      n_bad++;
      $display("FAIL flush_capture: got v=%b we=%b d=%h want 0 0 aaaa5555",
               wb_valid, wb_we, wb_data);
    end
    idle_inputs();
    tick();
  endtask

`ifdef WB_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    set_src(32'h1, 32'h2, 32'h3);
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd7;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (perf_wr_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL perf_five: got %0d want 5", perf_wr_cnt);
    end
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd0;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (perf_wr_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL perf_zero: got %0d want 5", perf_wr_cnt);
    end
    dut.perf_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd4;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (perf_wr_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_wrap: got %h want 0", perf_wr_cnt);
    end
  endtask
`endif

  task automatic test_mid_reset();
    set_src(32'hCAFEBABE, 32'h5, 32'h6);
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd_addr   = 5'd5;
    src_sel   = 2'd0;
    rst_n     = 1'b0;
    tick();
    n_cmp++;
    if ({wb_valid, wb_we, wb_addr, wb_data, sel_err} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b we=%b a=%0d d=%h e=%b want 0",
               wb_valid, wb_we, wb_addr, wb_data, sel_err);
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      err_clr   = ($urandom_range(0, 5) == 0);
      reg_write = 1'($urandom);
      src_sel   = SEL_W'($urandom_range(0, 3));
      rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : ADDR_W'($urandom);
      set_src($urandom, $urandom, $urandom);
      #1;
      n_cmp++;
      if (in_ready !== ~stall) begin
        n_bad++;
        $display("FAIL rand_ready%0d: got %b want %b", i, in_ready, ~stall);
      end
      tick();
      n_cmp++;
      if ({wb_valid, wb_we, wb_addr, wb_data, sel_err} !==
          {exp_v, exp_we, exp_addr, exp_data, exp_err}) begin
        n_bad++;
        $display("FAIL rand%0d: got v=%b we=%b a=%0d d=%h e=%b want %b %b %0d %h %b",
                 i, wb_valid, wb_we, wb_addr, wb_data, sel_err,
                 exp_v, exp_we, exp_addr, exp_data, exp_err);
      end
`ifdef WB_PERF_CNT_EN
      n_cmp++;
      if (perf_wr_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL rand_cnt%0d: got %0d want %0d", i, perf_wr_cnt, exp_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    set_src('0, '0, '0);
    rst_n    = 1'b0;
    exp_v    = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_err  = 1'b0;
    exp_cnt  = '0;
    #2;
    test_reset();
    test_mux();
    test_zero_illegal();
    test_stall_flush();
`ifdef WB_PERF_CNT_EN
    test_perf();
`endif
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
